pc_unit: RTL and testbench

Program-counter unit for the multicycle MIPS datapath. It holds the PC register and selects the next PC from the ALU result, ALU output register, pseudo-direct jump, jump-register or exception vector. It also evaluates BEQ/BNE conditional writes, captures EPC on exceptions and traps misaligned or invalid targets through a one-cycle fault sequence. It sits between the ALU/ALUOut register and the instruction-memory address port and is driven by the main control FSM.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_if.sv | 36 +++
 rtl/pc_next_mux.sv | 39 +++
 rtl/pc_unit.sv | 77 +++++++
 tb/tb_pc_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the MIPS program-counter unit.
// Next-PC select codes, FSM state type and default vectors.
package pc_pkg;

  localparam logic [2:0] PCSRC_ALURES = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_JR     = 3'd3;
  localparam logic [2:0] PCSRC_EXC    = 3'd4;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0180;

  typedef enum logic {
    NORMAL,
    FAULT
  } pc_state_t;

endpackage

// File: rtl/pc_if.sv
// pc_if: control/datapath bundle between the main FSM and the PC unit.
// master = control side, slave = pc_unit.
interface pc_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] AluRes;
  logic [WIDTH-1:0] AluOut;
  logic [WIDTH-1:0] RegA;
  logic [27:0]      Shift;
  logic [2:0]       PCSrc;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             Zero;
  logic             BranchNe;
  logic             Exception;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] EPC;
  logic             AddrFault;
  logic [WIDTH-1:0] BadAddr;

  modport master (
    output AluRes, AluOut, RegA, Shift, PCSrc,
    output PCWrite, PCWriteCond, Zero, BranchNe,
    output Exception,
    input  PC, EPC, AddrFault, BadAddr
  );

  modport slave (
    input  AluRes, AluOut, RegA, Shift, PCSrc,
    input  PCWrite, PCWriteCond, Zero, BranchNe,
    input  Exception,
    output PC, EPC, AddrFault, BadAddr
  );

endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC target select.
// Reserved select codes yield an all-ones target that always faults.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = EXC_VEC_DEF[WIDTH-1:0]
) (
  input  logic [2:0]       pc_src,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [27:0]      shift,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] target,
  output logic             misaligned
);

  logic rsv;

  always_comb begin
    target = '1;
    rsv    = 1'b0;
    case (pc_src)
      PCSRC_ALURES: target = alu_res;
      PCSRC_ALUOUT: target = alu_out;
      PCSRC_JUMP:   target = {pc[WIDTH-1:28], shift};
      PCSRC_JR:     target = reg_a;
      PCSRC_EXC:    target = EXC_VEC;
      default: begin
        target = '1;
        rsv    = 1'b1;
      end
    endcase
  end

  assign misaligned = rsv | (|target[1:0]);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC/EPC registers, branch take logic and one-cycle
// address-fault sequence for the multicycle MIPS datapath.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = RESET_VEC_DEF[WIDTH-1:0],
  parameter logic [WIDTH-1:0] EXC_VEC   = EXC_VEC_DEF[WIDTH-1:0]
) (
  input logic clk,
  input logic reset,
  pc_if.slave bus
);

  pc_state_t        state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] bad;
  logic             fault;
  logic [WIDTH-1:0] target;
  logic             misaligned;
  logic             take;

  pc_next_mux #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC)
  ) u_mux (
    .pc_src     (bus.PCSrc),
    .alu_res    (bus.AluRes),
    .alu_out    (bus.AluOut),
    .reg_a      (bus.RegA),
    .shift      (bus.Shift),
    .pc         (pc),
    .target     (target),
    .misaligned (misaligned)
  );

  assign take = bus.PCWrite
              | (bus.PCWriteCond & (bus.Zero ^ bus.BranchNe));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NORMAL;
      pc    <= RESET_VEC;
      epc   <= '0;
      bad   <= '0;
      fault <= 1'b0;
    end else begin
      unique case (state)
        NORMAL: begin
          if (bus.Exception) begin
            pc  <= EXC_VEC;
            epc <= pc;
          end else if (take && !misaligned) begin
            pc <= target;
          end else if (take) begin
            bad   <= target;
            fault <= 1'b1;
            state <= FAULT;
          end
        end
        FAULT: begin
          pc    <= EXC_VEC;
          epc   <= pc;
          fault <= 1'b0;
          state <= NORMAL;
        end
      endcase
    end
  end

  assign bus.PC        = pc;
  assign bus.EPC       = epc;
  assign bus.AddrFault = fault;
  assign bus.BadAddr   = bad;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector bench for pc_unit.
// Inputs change and outputs are sampled on the falling edge.
module tb_pc_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pc_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH     (32),
    .RESET_VEC (32'h0040_0000),
    .EXC_VEC   (32'h8000_0180)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.Exception   = 1'b0;
    bus.Zero        = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.PCSrc       = PCSRC_ALURES;
  endtask

  initial begin
    bus.AluRes = 32'h0000_1234;
    bus.AluOut = '0;
    bus.RegA   = '0;
    bus.Shift  = '0;
    idle();
    reset       = 1'b1;
    bus.PCWrite = 1'b1;
    @(negedge clk);
    step();
    reset = 1'b0;
    idle();
    check("rst_pc", bus.PC, 32'h0040_0000);
    check("rst_epc", bus.EPC, 32'h0);
    check("rst_bad", bus.BadAddr, 32'h0);
    check("rst_flt", {31'b0, bus.AddrFault}, 32'h0);

    bus.AluRes  = 32'h0040_0004;
    bus.PCWrite = 1'b1;
    step();
    check("alures", bus.PC, 32'h0040_0004);

    bus.PCSrc = PCSRC_JUMP;
    bus.Shift = 28'h000_0100;
    step();
    check("jump", bus.PC, 32'h0000_0100);

    idle();
    bus.PCWriteCond = 1'b1;
    bus.PCSrc       = PCSRC_ALUOUT;
    bus.AluOut      = 32'h0040_0020;
    bus.Zero        = 1'b1;
    step();
    check("beq_take", bus.PC, 32'h0040_0020);

    bus.BranchNe = 1'b1;
    bus.AluOut   = 32'h0040_0040;
    step();
    check("bne_hold", bus.PC, 32'h0040_0020);

    bus.Zero = 1'b0;
    step();
    check("bne_take", bus.PC, 32'h0040_0040);

    idle();
    bus.PCWriteCond = 1'b1;
    bus.AluOut      = 32'h0040_0080;
    bus.PCSrc       = PCSRC_ALUOUT;
    step();
    check("beq_nz_hold", bus.PC, 32'h0040_0040);

    idle();
    bus.PCSrc   = PCSRC_JR;
    bus.RegA    = 32'h0040_0002;
    bus.PCWrite = 1'b1;
    step();
    check("jr_flt", {31'b0, bus.AddrFault}, 32'h1);
    check("jr_bad", bus.BadAddr, 32'h0040_0002);
    check("jr_hold", bus.PC, 32'h0040_0040);
    bus.Exception = 1'b1;
    bus.RegA      = 32'h0040_0008;
    step();
    idle();
    check("jr_flt_end", {31'b0, bus.AddrFault}, 32'h0);
    check("jr_vec", bus.PC, 32'h8000_0180);
    check("jr_epc", bus.EPC, 32'h0040_0040);
    check("jr_bad_hold", bus.BadAddr, 32'h0040_0002);

    bus.AluRes  = 32'h0040_0100;
    bus.PCWrite = 1'b1;
    step();
    check("set_pc", bus.PC, 32'h0040_0100);
    bus.PCSrc = 3'b111;
    step();
    idle();
    check("rsv_flt", {31'b0, bus.AddrFault}, 32'h1);
    check("rsv_bad", bus.BadAddr, 32'hFFFF_FFFF);
    step();
    check("rsv_vec", bus.PC, 32'h8000_0180);
    check("rsv_epc", bus.EPC, 32'h0040_0100);

    bus.AluRes  = 32'h0040_0300;
    bus.PCWrite = 1'b1;
    step();
    bus.AluRes    = 32'h0040_0200;
    bus.Exception = 1'b1;
    step();
    idle();
    check("exc_vec", bus.PC, 32'h8000_0180);
    check("exc_epc", bus.EPC, 32'h0040_0300);
    check("exc_noflt", {31'b0, bus.AddrFault}, 32'h0);

    reset = 1'b1;
    step();
    reset         = 1'b0;
    bus.PCSrc     = PCSRC_JR;
    bus.RegA      = 32'h0040_0006;
    bus.PCWrite   = 1'b1;
    step();
    idle();
    check("rf_flt", {31'b0, bus.AddrFault}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rf_pc", bus.PC, 32'h0040_0000);
    check("rf_flt_clr", {31'b0, bus.AddrFault}, 32'h0);
    check("rf_epc", bus.EPC, 32'h0);
    step();
    check("rf_pc_hold", bus.PC, 32'h0040_0000);
    check("rf_epc_hold", bus.EPC, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
